// File: rtl/cordic_vectoring_detector.sv
// Vectoring-mode CORDIC: converts one Cartesian sample (x, y) into magnitude
// and phase. Phase is in pi units (2^N_FRAC LSB = pi, two's-complement wrap),
// magnitude in signed Q0.N_FRAC, matching the sine generator input format.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for an input strobe; results held on the outputs
// ST_ITER  | one micro-rotation per cycle, i = 0 .. N_ITER-1
// ST_SCALE | gain compensation, rounding, saturation, output register load

`timescale 1ns/1ps

module cordic_vectoring_detector #(
    parameter int N_FRAC = 7,
    parameter int N_ITER = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic signed [N_FRAC:0] x_i,
    input  logic signed [N_FRAC:0] y_i,
    input  logic                data_in_valid_strobe_i,
    output logic signed [N_FRAC:0] amplitude_o,
    output logic signed [N_FRAC:0] phase_o,
    output logic                busy_o,
    output logic                data_out_valid_strobe_o
);

    localparam int P  = N_FRAC + 1;
    localparam int W  = N_FRAC + 5;
    localparam int ZW = N_FRAC + 3;
    localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    // z scale: 2^(ZW-1) = pi, so pi/2 is 2^(ZW-2)
    localparam logic signed [ZW-1:0] Z_HALF_PI     = {2'b01, {(ZW-2){1'b0}}};
    localparam logic signed [ZW-1:0] Z_NEG_HALF_PI = {2'b11, {(ZW-2){1'b0}}};
    localparam logic signed [ZW-1:0] Z_ROUND       = ZW'(2);
    localparam logic signed [W-1:0]  AMP_MAX       = W'((1 << N_FRAC) - 1);

    // atan(2^-i)/pi scaled by 2^24; beyond i=11 atan(x) ~ x is exact enough
    function automatic longint atan_q24(input int i);
        case (i)
            0:  return longint'(4194304);
            1:  return longint'(2476042);
            2:  return longint'(1308273);
            3:  return longint'(664100);
            4:  return longint'(333339);
            5:  return longint'(166832);
            6:  return longint'(83436);
            7:  return longint'(41721);
            8:  return longint'(20861);
            9:  return longint'(10430);
            10: return longint'(5215);
            11: return longint'(2608);
            default: return longint'(5340354) >>> i;
        endcase
    endfunction

    // round(atan(2^-i)/pi * 2^(N_FRAC+2)), derived from the 2^24 table
    function automatic logic signed [ZW-1:0] atan_step(input int i);
        longint v;
        int     s;
        s = 22 - N_FRAC;
        v = atan_q24(i);
        if (s > 0)
            v = (v + (longint'(1) << (s - 1))) >>> s;
        else
            v = v <<< (-s);
        return ZW'(v);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_SCALE
    } state_t;

    state_t state_q, state_d;

    logic signed [W-1:0]  x_q, y_q;
    logic signed [ZW-1:0] z_q;
    logic [IW-1:0]        iter_q;
    logic                 zero_q;

    logic signed [P-1:0]  amplitude_q, phase_q;
    logic                 valid_q;

    logic signed [ZW-1:0] atan_rom [N_ITER];

    for (genvar g = 0; g < N_ITER; g++) begin : g_atan
        assign atan_rom[g] = atan_step(g);
    end

    logic signed [W-1:0]  x_ext, y_ext;
    logic signed [W-1:0]  x_load, y_load;
    logic signed [ZW-1:0] z_load;
    logic signed [W-1:0]  x_sh, y_sh;
    logic signed [W-1:0]  x_rot, y_rot;
    logic signed [ZW-1:0] z_rot;
    logic signed [ZW-1:0] atan_cur;
    logic signed [W-1:0]  gain_x, amp_full;
    logic signed [P-1:0]  amp_sat;
    logic signed [ZW-1:0] z_round;
    logic signed [P-1:0]  phase_rnd;
    logic                 last_iter;

    // sign-extend and move into the guard-bit format (two guard LSBs)
    assign x_ext = {{2{x_i[N_FRAC]}}, x_i, 2'b00};
    assign y_ext = {{2{y_i[N_FRAC]}}, y_i, 2'b00};

    assign last_iter = (iter_q == IW'(N_ITER - 1));

    // pre-rotation into the right half-plane so the iterations can converge
    always_comb begin
        x_load = x_ext;
        y_load = y_ext;
        z_load = '0;
        if (x_ext[W-1]) begin
            if (!y_ext[W-1]) begin
                x_load = y_ext;
                y_load = -x_ext;
                z_load = Z_HALF_PI;
            end else begin
                x_load = -y_ext;
                y_load = x_ext;
                z_load = Z_NEG_HALF_PI;
            end
        end
    end

    // one micro-rotation driving y toward zero; both updates use pre-cycle x/y
    always_comb begin
        atan_cur = atan_rom[iter_q];
        x_sh     = x_q >>> iter_q;
        y_sh     = y_q >>> iter_q;
        if (!y_q[W-1]) begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + atan_cur;
        end else begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - atan_cur;
        end
    end

    // gain compensation (~0.6073), guard-bit removal, saturation, phase rounding
    always_comb begin
        gain_x   = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
        amp_full = gain_x >>> 2;
        if (amp_full[W-1])
            amp_sat = '0;
        else if (amp_full > AMP_MAX)
            amp_sat = AMP_MAX[P-1:0];
        else
            amp_sat = amp_full[P-1:0];
        z_round   = z_q + Z_ROUND;
        phase_rnd = P'(z_round >>> 2);
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (data_in_valid_strobe_i) state_d = ST_ITER;
            ST_ITER:  if (last_iter) state_d = ST_SCALE;
            ST_SCALE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // datapath and output registers, sequenced by the current state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= '0;
            zero_q      <= 1'b0;
            amplitude_q <= '0;
            phase_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (data_in_valid_strobe_i) begin
                        x_q    <= x_load;
                        y_q    <= y_load;
                        z_q    <= z_load;
                        iter_q <= '0;
                        zero_q <= (x_i == '0) && (y_i == '0);
                    end
                end
                ST_ITER: begin
                    x_q    <= x_rot;
                    y_q    <= y_rot;
                    z_q    <= z_rot;
                    iter_q <= iter_q + 1'b1;
                end
                ST_SCALE: begin
                    amplitude_q <= zero_q ? '0 : amp_sat;
                    phase_q     <= zero_q ? '0 : phase_rnd;
                    valid_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign amplitude_o             = amplitude_q;
    assign phase_o                 = phase_q;
    assign busy_o                  = (state_q != ST_IDLE);
    assign data_out_valid_strobe_o = valid_q;

endmodule

// File: tb/tb_cordic_vectoring_detector.sv
// Directed bench for cordic_vectoring_detector: reset, cardinal points,
// diagonals, saturation, handshake, mid-conversion reset and a loopback sweep.

`timescale 1ns/1ps

module tb_cordic_vectoring_detector;

    localparam int N_FRAC = 7;
    localparam int N_ITER = 8;
    localparam int LAT    = N_ITER + 2;
    localparam real PI    = 3.14159265358979;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic signed [N_FRAC:0] x_i;
    logic signed [N_FRAC:0] y_i;
    logic                  data_in_valid_strobe_i;
    logic signed [N_FRAC:0] amplitude_o;
    logic signed [N_FRAC:0] phase_o;
    logic                  busy_o;
    logic                  data_out_valid_strobe_o;

    int n_vec = 0;
    int n_err = 0;

    cordic_vectoring_detector #(
        .N_FRAC(N_FRAC),
        .N_ITER(N_ITER)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .x_i                    (x_i),
        .y_i                    (y_i),
        .data_in_valid_strobe_i (data_in_valid_strobe_i),
        .amplitude_o            (amplitude_o),
        .phase_o                (phase_o),
        .busy_o                 (busy_o),
        .data_out_valid_strobe_o(data_out_valid_strobe_o)
    );

    always #5 clk_i = ~clk_i;

    // tolerance compare; with wrap set the difference is taken modulo 256
    task automatic check_val(input string tag, input int obs, input int exp_v,
                             input int tol, input bit wrap);
        int d;
        d = obs - exp_v;
        if (wrap) begin
            d = d % 256;
            if (d > 127)  d -= 256;
            if (d < -128) d += 256;
        end
        if (d < 0) d = -d;
        n_vec++;
        assert ((d <= tol) === 1'b1)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp_v, tol);
        end
    endtask

    // count negedges until the output strobe; optionally inject a strobe at cycle inj_at
    task automatic wait_valid(input int inj_at, input int ix, input int iy,
                              output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (c == inj_at) begin
                x_i = 8'(ix);
                y_i = 8'(iy);
                data_in_valid_strobe_i = 1'b1;
            end else begin
                data_in_valid_strobe_i = 1'b0;
            end
            if (data_out_valid_strobe_o) begin
                lat = c;
                if (busy_o) busy_ok = 1'b0;
                break;
            end
            if (!busy_o) busy_ok = 1'b0;
        end
    endtask

    task automatic convert(input string tag, input int xv, input int yv,
                           input int exp_amp, input int exp_ph,
                           input int tol_amp, input int tol_ph, output bit busy_ok);
        int lat;
        @(negedge clk_i);
        x_i = 8'(xv);
        y_i = 8'(yv);
        data_in_valid_strobe_i = 1'b1;
        wait_valid(0, 0, 0, lat, busy_ok);
        check_val({tag, "_lat"}, lat, LAT, 0, 1'b0);
        check_val({tag, "_amp"}, int'(amplitude_o), exp_amp, tol_amp, 1'b0);
        check_val({tag, "_ph"},  int'(phase_o), exp_ph, tol_ph, 1'b1);
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(-r + 0.5);
    endfunction

    initial begin
        bit busy_ok;
        int lat;
        int highs;

        rst_i = 1'b1;
        x_i   = '0;
        y_i   = '0;
        data_in_valid_strobe_i = 1'b0;

        // reset then idle
        repeat (2) @(negedge clk_i);
        check_val("rst_amp",   int'(amplitude_o), 0, 0, 1'b0);
        check_val("rst_ph",    int'(phase_o), 0, 0, 1'b0);
        check_val("rst_busy",  int'(busy_o), 0, 0, 1'b0);
        check_val("rst_valid", int'(data_out_valid_strobe_o), 0, 0, 1'b0);
        rst_i = 1'b0;
        highs = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (data_out_valid_strobe_o || busy_o) highs++;
        end
        check_val("idle_quiet", highs, 0, 0, 1'b0);

        // cardinal points
        convert("p64_0", 64, 0, 64, 0, 2, 2, busy_ok);
        check_val("busy_window", int'(busy_ok), 1, 0, 1'b0);
        @(negedge clk_i);
        check_val("valid_pulse", int'(data_out_valid_strobe_o), 0, 0, 1'b0);
        convert("p0_64",  0, 64, 64, 64, 2, 2, busy_ok);
        convert("pm64_0", -64, 0, 64, -128, 2, 2, busy_ok);
        convert("p0_m100", 0, -100, 100, -64, 2, 2, busy_ok);

        // outputs hold while inputs wander without a strobe
        x_i = 8'sd17;
        y_i = -8'sd90;
        repeat (6) @(negedge clk_i);
        check_val("hold_amp", int'(amplitude_o), 100, 2, 1'b0);
        check_val("hold_ph",  int'(phase_o), -64, 2, 1'b1);

        // diagonals, saturation, zero
        convert("d45",    45, 45, 64, 32, 2, 2, busy_ok);
        convert("dm45",   -45, -45, 64, -96, 2, 2, busy_ok);
        convert("corner", -128, -128, 127, -96, 0, 2, busy_ok);
        convert("zero",   0, 0, 0, 0, 0, 0, busy_ok);

        // strobe while busy is ignored; strobe in the valid cycle is accepted
        @(negedge clk_i);
        x_i = 8'sd64;
        y_i = 8'sd0;
        data_in_valid_strobe_i = 1'b1;
        wait_valid(3, 0, 64, lat, busy_ok);
        check_val("hs1_lat", lat, LAT, 0, 1'b0);
        check_val("hs1_amp", int'(amplitude_o), 64, 2, 1'b0);
        check_val("hs1_ph",  int'(phase_o), 0, 2, 1'b1);
        x_i = 8'sd0;
        y_i = -8'sd100;
        data_in_valid_strobe_i = 1'b1;
        wait_valid(0, 0, 0, lat, busy_ok);
        check_val("hs2_lat", lat, LAT, 0, 1'b0);
        check_val("hs2_amp", int'(amplitude_o), 100, 2, 1'b0);
        check_val("hs2_ph",  int'(phase_o), -64, 2, 1'b1);

        // reset in the middle of a conversion
        @(negedge clk_i);
        x_i = 8'sd45;
        y_i = 8'sd45;
        data_in_valid_strobe_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            data_in_valid_strobe_i = 1'b0;
            if (c == 5) rst_i = 1'b1;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        check_val("mrst_amp",  int'(amplitude_o), 0, 0, 1'b0);
        check_val("mrst_ph",   int'(phase_o), 0, 0, 1'b0);
        check_val("mrst_busy", int'(busy_o), 0, 0, 1'b0);
        highs = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (data_out_valid_strobe_o) highs++;
        end
        check_val("mrst_nostrobe", highs, 0, 0, 1'b0);
        convert("after_rst", 0, 64, 64, 64, 2, 2, busy_ok);

        // loopback sweep A=100, k*pi/64
        for (int k = 0; k < 128; k++) begin
            int xv, yv;
            xv = rnd(100.0 * $cos(real'(k) * PI / 64.0));
            yv = rnd(100.0 * $sin(real'(k) * PI / 64.0));
            convert($sformatf("sweep%0d", k), xv, yv, 100, 2 * k, 2, 2, busy_ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring_detector.md
Name: cordic_vectoring_detector

Overview:
- Inverse of the sine generation path: takes one Cartesian sample pair (x, y) and returns its magnitude and phase.
- Uses an iterative vectoring-mode CORDIC driven by a small FSM.
- Output format matches the generator inputs: phase in pi units, where 2^N_FRAC LSB = pi and values wrap two's complement; amplitude in signed Q0.N_FRAC.
- Used to close the loop on generated waves: the demodulator side and loopback self-check.

Parameters:
- N_FRAC, 7, fractional bits of all data ports; port width is N_FRAC+1.
- N_ITER, 8, CORDIC micro-rotations; 1 <= N_ITER <= N_FRAC+1.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- x_i  in  N_FRAC+1  signed in-phase sample.
- y_i  in  N_FRAC+1  signed quadrature sample.
- data_in_valid_strobe_i  in  1  single-cycle pulse; x_i/y_i valid.
- amplitude_o  out  N_FRAC+1  signed magnitude, always >= 0.
- phase_o  out  N_FRAC+1  signed angle atan2(y,x); 2^N_FRAC LSB = pi.
- busy_o  out  1  high while a conversion is in flight.
- data_out_valid_strobe_o  out  1  single-cycle pulse; amplitude_o/phase_o updated.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FSM goes to IDLE.
  - amplitude_o=0, phase_o=0, busy_o=0, data_out_valid_strobe_o=0.
  - Any in-flight conversion is discarded; no strobe is issued for it.
- Internal datapath:
  - x/y width W = N_FRAC+5: sign, 2 integer bits, N_FRAC fractional bits, 2 guard bits. Inputs are shifted left by 2 on load.
  - z width N_FRAC+3 (2 guard bits), wraps modulo 2^(N_FRAC+3).
- FSM states: IDLE, ITER, SCALE.
  - IDLE -> ITER: data_in_valid_strobe_i=1 while busy_o=0.
    - Capture x_i, y_i and apply pre-rotation. If x>=0: unchanged, z0=0. If x<0 and y>=0: (x,y) <- (y,-x), z0=+pi/2. If x<0 and y<0: (x,y) <- (-y,x), z0=-pi/2.
    - Flag zero_in if x_i=y_i=0.
    - Clear iteration counter i.
  - ITER, one micro-rotation per cycle for i=0..N_ITER-1:
    - If y>=0: x+=y>>>i, y-=x>>>i, z+=atan_i.
    - Else: x-=y>>>i, y+=x>>>i, z-=atan_i.
    - Both updates use the pre-cycle x/y values.
    - atan_i = round(atan(2^-i)/pi * 2^(N_FRAC+2)). For N_FRAC=7: 128, 76, 40, 20, 10, 5, 3, 1.
    - After i=N_ITER-1 go to SCALE.
  - SCALE -> IDLE, one cycle:
    - Gain compensation: a = (x>>1)+(x>>3)-(x>>6)-(x>>9), about x*0.6073.
    - Remove guard bits by truncation; saturate to 2^N_FRAC-1.
    - phase = (z+2)>>>2, wrapped to N_FRAC+1 bits.
    - If zero_in: amplitude 0, phase 0.
    - Register amplitude_o and phase_o; pulse data_out_valid_strobe_o for one cycle, in the first IDLE cycle.
- Latency: strobe accepted at edge t; data_out_valid_strobe_o is high in cycle t+N_ITER+2 (10 for defaults).
- busy_o:
  - High from t+1 through t+N_ITER+1.
  - Low in the cycle the valid strobe is high, so a new input strobe in that same cycle is accepted.
  - Throughput: one sample per N_ITER+2 cycles.
- Input strobes while busy_o=1 are ignored: no queueing, no corruption of the in-flight result.
- amplitude_o/phase_o hold their value between valid strobes.
- Boundary cases:
  - Angle exactly pi (x<0, y=0) yields phase 0x80 (-pi); +/-1 LSB wrap to 0x7F is acceptable.
  - Full-scale corner x=y=-2^N_FRAC: must not overflow W, and amplitude saturates to 0x7F.
  - Amplitude is never negative.
- Accuracy: within +/-2 LSB of ideal on both outputs for N_FRAC=7, N_ITER=8.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> all outputs 0, no strobe.
- Cardinal points, one strobe each, expected amplitude/phase (+/-2 LSB):
  - (64,0) -> 64/0
  - (0,64) -> 64/64
  - (-64,0) -> 64/-128 (or 127)
  - (0,-100) -> 100/-64
  - In every case the strobe arrives exactly 10 cycles after the input strobe.
- Diagonals and saturation:
  - (45,45) -> ~64/32
  - (-45,-45) -> ~64/-96
  - (-128,-128) -> 127 saturated, phase -96
  - (0,0) -> 0/0
- Handshake: a second strobe 3 cycles after the first is ignored (result equals the first input only). A strobe in the valid-strobe cycle is accepted, and its result arrives 10 cycles later.
- Reset mid-operation: rst_i=1 at cycle 5 of a conversion -> no output strobe, outputs 0, busy_o=0. The next conversion is correct.
- Loopback sweep: feed rotated vectors (A*cos(k*pi/64), A*sin(k*pi/64)) for A=100 and k=0..127 -> amplitude 100+/-2, phase equals k*2 wrapped, +/-2 LSB.
